// File: rtl/morse_rx_decoder.sv
// Morse receiver: measures keyed-line mark/space runs, collects dots and dashes
// and emits one ASCII byte per letter plus 0x20 per word gap. Define
// MORSE_RX_DIGITS_EN to also decode the 5-element digit codes 0-9.
module morse_rx_decoder #(
   parameter int UNIT_CYCLES = 4,
   parameter int CNT_W       = 14
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key,
   output logic [7:0] data,
   output logic       valid,
   output logic       err
);

   localparam logic [CNT_W-1:0] DASH_MIN   = CNT_W'(2 * UNIT_CYCLES);
   localparam logic [CNT_W-1:0] LETTER_GAP = CNT_W'(2 * UNIT_CYCLES);
   localparam logic [CNT_W-1:0] WORD_GAP   = CNT_W'(5 * UNIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MARK  = 2'd1,
      S_SPACE = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             key_r;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] mark_len;
   logic [2:0]       len;
   logic [5:0]       bits;
   logic             ovf;
   logic             append;
   logic             emit_char;
   logic             emit_space;
   logic             elem_dash;
   logic [8:0]       code;

   // Returns {err, ascii}; bits above len are always zero, so {len, bits} is unique.
   function automatic logic [8:0] lookup(input logic [2:0] l, input logic [5:0] b);
      logic [8:0] r;
      r = {1'b1, 8'h3F};
      case ({l, b})
         {3'd2, 6'b000001}: r = {1'b0, 8'h41};
         {3'd4, 6'b001000}: r = {1'b0, 8'h42};
         {3'd4, 6'b001010}: r = {1'b0, 8'h43};
         {3'd3, 6'b000100}: r = {1'b0, 8'h44};
         {3'd1, 6'b000000}: r = {1'b0, 8'h45};
         {3'd4, 6'b000010}: r = {1'b0, 8'h46};
         {3'd3, 6'b000110}: r = {1'b0, 8'h47};
         {3'd4, 6'b000000}: r = {1'b0, 8'h48};
         {3'd2, 6'b000000}: r = {1'b0, 8'h49};
         {3'd4, 6'b000111}: r = {1'b0, 8'h4A};
         {3'd3, 6'b000101}: r = {1'b0, 8'h4B};
         {3'd4, 6'b000100}: r = {1'b0, 8'h4C};
         {3'd2, 6'b000011}: r = {1'b0, 8'h4D};
         {3'd2, 6'b000010}: r = {1'b0, 8'h4E};
         {3'd3, 6'b000111}: r = {1'b0, 8'h4F};
         {3'd4, 6'b000110}: r = {1'b0, 8'h50};
         {3'd4, 6'b001101}: r = {1'b0, 8'h51};
         {3'd3, 6'b000010}: r = {1'b0, 8'h52};
         {3'd3, 6'b000000}: r = {1'b0, 8'h53};
         {3'd1, 6'b000001}: r = {1'b0, 8'h54};
         {3'd3, 6'b000001}: r = {1'b0, 8'h55};
         {3'd4, 6'b000001}: r = {1'b0, 8'h56};
         {3'd3, 6'b000011}: r = {1'b0, 8'h57};
         {3'd4, 6'b001001}: r = {1'b0, 8'h58};
         {3'd4, 6'b001011}: r = {1'b0, 8'h59};
         {3'd4, 6'b001100}: r = {1'b0, 8'h5A};
`ifdef MORSE_RX_DIGITS_EN
         {3'd5, 6'b011111}: r = {1'b0, 8'h30};
         {3'd5, 6'b001111}: r = {1'b0, 8'h31};
         {3'd5, 6'b000111}: r = {1'b0, 8'h32};
         {3'd5, 6'b000011}: r = {1'b0, 8'h33};
         {3'd5, 6'b000001}: r = {1'b0, 8'h34};
         {3'd5, 6'b000000}: r = {1'b0, 8'h35};
         {3'd5, 6'b010000}: r = {1'b0, 8'h36};
         {3'd5, 6'b011000}: r = {1'b0, 8'h37};
         {3'd5, 6'b011100}: r = {1'b0, 8'h38};
         {3'd5, 6'b011110}: r = {1'b0, 8'h39};
`endif
         default: r = {1'b1, 8'h3F};
      endcase
      return r;
   endfunction

   // cnt holds the number of cycles key_r has been at its present level;
   // mark_len latches the finished mark run on the falling edge of the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_r    <= 1'b0;
         cnt      <= '0;
         mark_len <= '0;
      end else begin
         key_r <= key;
         if (key != key_r)
            cnt <= CNT_ONE;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
         if (key_r && !key)
            mark_len <= cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (key_r) state_next = S_MARK;
         S_MARK:  if (!key_r) state_next = S_SPACE;
         S_SPACE: begin
            if (key_r)
               state_next = S_MARK;
            else if (cnt >= LETTER_GAP)
               state_next = S_GAP;
         end
         S_GAP: begin
            if (key_r)
               state_next = S_MARK;
            else if (cnt >= WORD_GAP)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // A rising line in SPACE/GAP is checked first: cnt then counts mark cycles.
   always_comb begin
      append     = 1'b0;
      emit_char  = 1'b0;
      emit_space = 1'b0;
      case (state)
         S_MARK:  append     = !key_r;
         S_SPACE: emit_char  = !key_r && (cnt >= LETTER_GAP);
         S_GAP:   emit_space = !key_r && (cnt >= WORD_GAP);
         default: ;
      endcase
   end

   assign elem_dash = (mark_len >= DASH_MIN);
   assign code      = lookup(len, bits);

   always_ff @(posedge clk) begin
      if (rst) begin
         len   <= 3'd0;
         bits  <= 6'd0;
         ovf   <= 1'b0;
         data  <= 8'h00;
         valid <= 1'b0;
         err   <= 1'b0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         if (append) begin
            if (len == 3'd6) begin
               ovf <= 1'b1;
            end else begin
               bits <= {bits[4:0], elem_dash};
               len  <= len + 3'd1;
            end
         end
         if (emit_char) begin
            valid <= 1'b1;
            data  <= ovf ? 8'h3F : code[7:0];
            err   <= ovf | code[8];
            len   <= 3'd0;
            bits  <= 6'd0;
            ovf   <= 1'b0;
         end
         if (emit_space) begin
            valid <= 1'b1;
            data  <= 8'h20;
         end
      end
   end

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Bench for morse_rx_decoder: key waveforms are built as run lists, a run-level
// Morse model predicts every strobe (edge, err, byte), and a monitor records the DUT's.
module tb_morse_rx_decoder;

   localparam int U = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       err;

   int n_cmp  = 0;
   int n_fail = 0;
   int edge_n = 0;

   // Event word: {edge number of the strobe, err, data}
   logic [40:0] exp_q[$];
   logic [40:0] obs_q[$];
   int          run_q[$];
   int          start_q[$];

   string tbl[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                      "..-", "...-", ".--", "-..-", "-.--", "--..",
                      "-----", ".----", "..---", "...--", "....-",
                      ".....", "-....", "--...", "---..", "----."};

   morse_rx_decoder #(.UNIT_CYCLES(U), .CNT_W(14)) dut (
      .clk   (clk),
      .rst   (rst),
      .key   (key),
      .data  (data),
      .valid (valid),
      .err   (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   always @(negedge clk) begin
      if (valid === 1'b1)
         obs_q.push_back({32'(edge_n), err, data});
   end

   function automatic logic [8:0] decode(string c);
      for (int i = 0; i < 26; i++)
         if (tbl[i] == c) return {1'b0, 8'(65 + i)};
`ifdef MORSE_RX_DIGITS_EN
      for (int i = 26; i < 36; i++)
         if (tbl[i] == c) return {1'b0, 8'(48 + i - 26)};
`endif
      return {1'b1, 8'h3F};
   endfunction

   task automatic hi(input int n);
      run_q.push_back(n);
   endtask

   task automatic lo(input int n);
      run_q.push_back(-n);
   endtask

   // Dots are 1 unit and dashes 3 units, elements separated by 1 unit.
   task automatic add_code(input string c, input int gap);
      for (int k = 0; k < c.len(); k++) begin
         hi((c[k] == "-") ? 3 * U : U);
         if (k < c.len() - 1) lo(U);
      end
      lo(gap);
   endtask

   // Drives run_q onto key and predicts strobes from run lengths alone.
   task automatic play();
      string      c;
      logic       pend;
      int         n;
      int         start;
      logic [8:0] d;
      c = "";
      pend = 1'b0;
      obs_q.delete();
      exp_q.delete();
      start_q.delete();
      foreach (run_q[i]) begin
         n = (run_q[i] > 0) ? run_q[i] : -run_q[i];
         start = edge_n + 1;
         start_q.push_back(start);
         if (run_q[i] > 0) begin
            key = 1'b1;
            c = {c, (n >= 2 * U) ? "-" : "."};
            pend = 1'b1;
         end else begin
            key = 1'b0;
            if (pend && n >= 2 * U) begin
               d = decode(c);
               exp_q.push_back({32'(start + 2 * U), d});
               if (n >= 5 * U) exp_q.push_back({32'(start + 5 * U), 1'b0, 8'h20});
               c = "";
               pend = 1'b0;
            end
         end
         repeat (n) @(negedge clk);
      end
      key = 1'b0;
      repeat (4) @(negedge clk);
      run_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      key = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
      n_cmp++;
      if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
      n_cmp++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
      rst = 1'b0;
      obs_q.delete();
      repeat (10 * U) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== 0) begin n_fail++; $display("FAIL reset_idle: got %0d strobes expected 0", obs_q.size()); end
   endtask

   task automatic test_single_e();
      logic [40:0] got;
      hi(U);
      lo(30);
      play();
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL e_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : '1;
         n_cmp++;
         if (got !== exp_q[i]) begin
            n_fail++;
            $display("FAIL e[%0d]: got edge %0d err %b data %h, expected edge %0d err %b data %h",
                     i, got[40:9], got[8], got[7:0], exp_q[i][40:9], exp_q[i][8], exp_q[i][7:0]);
         end
      end
      got = (obs_q.size() > 0) ? obs_q[0] : '1;
      n_cmp++;
      if (got[8:0] !== {1'b0, 8'h45} || int'(got[40:9]) - start_q[1] + 1 !== 2 * U + 1) begin
         n_fail++;
         $display("FAIL e_letter: got rel edge %0d err %b data %h, expected rel edge %0d err 0 data 45",
                  int'(got[40:9]) - start_q[1] + 1, got[8], got[7:0], 2 * U + 1);
      end
      got = (obs_q.size() > 1) ? obs_q[1] : '1;
      n_cmp++;
      if (got[8:0] !== {1'b0, 8'h20} || int'(got[40:9]) - start_q[1] + 1 !== 5 * U + 1) begin
         n_fail++;
         $display("FAIL e_space: got rel edge %0d err %b data %h, expected rel edge %0d err 0 data 20",
                  int'(got[40:9]) - start_q[1] + 1, got[8], got[7:0], 5 * U + 1);
      end
      n_cmp++;
      if (data !== 8'h20 || valid !== 1'b0) begin
         n_fail++; $display("FAIL e_hold: got data %h valid %b, expected data 20 valid 0", data, valid);
      end
   endtask

   task automatic test_dash_boundary();
      logic [40:0] got;
      logic [7:0]  want[4];
      want = '{8'h41, 8'h45, 8'h54, 8'h54};
      add_code(".-", 3 * U);
      hi(2 * U - 1);
      lo(3 * U);
      hi(2 * U);
      lo(3 * U);
      hi(16400);
      lo(8 * U);
      play();
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL dash_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : '1;
         n_cmp++;
         if (got !== exp_q[i]) begin
            n_fail++;
            $display("FAIL dash[%0d]: got edge %0d err %b data %h, expected edge %0d err %b data %h",
                     i, got[40:9], got[8], got[7:0], exp_q[i][40:9], exp_q[i][8], exp_q[i][7:0]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : '1;
         n_cmp++;
         if (got[7:0] !== want[i]) begin
            n_fail++; $display("FAIL dash_letter[%0d]: got %h expected %h", i, got[7:0], want[i]);
         end
      end
   endtask

   task automatic test_sos_word();
      logic [40:0] got;
      logic [7:0]  want[5];
      want = '{8'h53, 8'h4F, 8'h53, 8'h20, 8'h45};
      add_code("...", 3 * U);
      add_code("---", 3 * U);
      add_code("...", 7 * U);
      add_code(".", 8 * U);
      play();
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL sos_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : '1;
         n_cmp++;
         if (got !== exp_q[i]) begin
            n_fail++;
            $display("FAIL sos[%0d]: got edge %0d err %b data %h, expected edge %0d err %b data %h",
                     i, got[40:9], got[8], got[7:0], exp_q[i][40:9], exp_q[i][8], exp_q[i][7:0]);
         end
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : '1;
         n_cmp++;
         if (got[7:0] !== want[i]) begin
            n_fail++; $display("FAIL sos_seq[%0d]: got %h expected %h", i, got[7:0], want[i]);
         end
      end
   endtask

   task automatic test_overflow_digit();
      logic [40:0] got;
      add_code(".......", 3 * U);
      add_code("-", 3 * U);
      add_code(".....", 8 * U);
      play();
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL ovf_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : '1;
         n_cmp++;
         if (got !== exp_q[i]) begin
            n_fail++;
            $display("FAIL ovf[%0d]: got edge %0d err %b data %h, expected edge %0d err %b data %h",
                     i, got[40:9], got[8], got[7:0], exp_q[i][40:9], exp_q[i][8], exp_q[i][7:0]);
         end
      end
      got = (obs_q.size() > 0) ? obs_q[0] : '1;
      n_cmp++;
      if (got[8:0] !== {1'b1, 8'h3F}) begin
         n_fail++; $display("FAIL ovf_sub: got err %b data %h expected err 1 data 3f", got[8], got[7:0]);
      end
      got = (obs_q.size() > 1) ? obs_q[1] : '1;
      n_cmp++;
      if (got[8:0] !== {1'b0, 8'h54}) begin
         n_fail++; $display("FAIL ovf_next: got err %b data %h expected err 0 data 54", got[8], got[7:0]);
      end
      got = (obs_q.size() > 2) ? obs_q[2] : '1;
      n_cmp++;
`ifdef MORSE_RX_DIGITS_EN
      if (got[8:0] !== {1'b0, 8'h35}) begin
         n_fail++; $display("FAIL digit5: got err %b data %h expected err 0 data 35", got[8], got[7:0]);
      end
`else
      if (got[8:0] !== {1'b1, 8'h3F}) begin
         n_fail++; $display("FAIL digit5: got err %b data %h expected err 1 data 3f", got[8], got[7:0]);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [40:0] got;
      obs_q.delete();
      key = 1'b1; repeat (U) @(negedge clk);
      key = 1'b0; repeat (U) @(negedge clk);
      key = 1'b1; repeat (U) @(negedge clk);
      key = 1'b0; repeat (2) @(negedge clk);
      rst = 1'b1; @(negedge clk);
      rst = 1'b0; repeat (40) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_strobes: got %0d expected 0", obs_q.size()); end
      n_cmp++;
      if (data !== 8'h00 || valid !== 1'b0 || err !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_outputs: got data %h valid %b err %b expected 00 0 0", data, valid, err);
      end
      add_code(".", 8 * U);
      play();
      got = (obs_q.size() > 0) ? obs_q[0] : '1;
      n_cmp++;
      if (obs_q.size() !== 2 || got !== exp_q[0]) begin
         n_fail++;
         $display("FAIL rstmid_e: got %0d strobes, first edge %0d err %b data %h, expected edge %0d err 0 data 45",
                  obs_q.size(), got[40:9], got[8], got[7:0], exp_q[0][40:9]);
      end
   endtask

   // Random element strings (1..7 elements) with random mark and gap lengths
   // that straddle the dot/dash, letter and word thresholds.
   task automatic test_random();
      logic [40:0] got;
      int          nl;
      int          ne;
      for (int it = 0; it < 8; it++) begin
         nl = $urandom_range(1, 4);
         for (int l = 0; l < nl; l++) begin
            ne = $urandom_range(1, 7);
            for (int e = 0; e < ne; e++) begin
               if ($urandom_range(0, 1) == 1) hi($urandom_range(2 * U, 4 * U));
               else hi($urandom_range(1, 2 * U - 1));
               if (e < ne - 1) lo($urandom_range(1, 2 * U - 1));
            end
            if (l < nl - 1) lo($urandom_range(2 * U - 1, 7 * U));
            else lo(8 * U);
         end
         play();
         n_cmp++;
         if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand%0d_count: got %0d strobes expected %0d", it, obs_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : '1;
            n_cmp++;
            if (got !== exp_q[i]) begin
               n_fail++;
               $display("FAIL rand%0d[%0d]: got edge %0d err %b data %h, expected edge %0d err %b data %h",
                        it, i, got[40:9], got[8], got[7:0], exp_q[i][40:9], exp_q[i][8], exp_q[i][7:0]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_e();
      test_dash_boundary();
      test_sos_word();
      test_overflow_digit();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
